// File: rtl/fpu_pkg.sv
// Shared FPU definitions: rounding-mode encoding, operand classes, integer
// saturation constants and the unpacked-operand record produced by the first
// stage of the float-to-integer converters.
package fpu_pkg;

  // RISC-V rounding-mode field encoding
  typedef enum logic [2:0] {
    RM_RNE = 3'b000,
    RM_RTZ = 3'b001,
    RM_RDN = 3'b010,
    RM_RUP = 3'b011,
    RM_RMM = 3'b100
  } rm_e;

  typedef enum logic [2:0] {
    CLS_ZERO,
    CLS_DENORM,
    CLS_NAN,
    CLS_INF,
    CLS_NORMAL
  } fclass_e;

  localparam int          BIAS    = 127;
  localparam logic [31:0] INT_MAX = 32'h7FFF_FFFF;
  localparam logic [31:0] INT_MIN = 32'h8000_0000;

  // Unpacked binary32 operand after classification
  typedef struct packed {
    logic               sign;
    fclass_e            cls;
    logic signed [8:0]  e;     // unbiased exponent
    logic        [23:0] mant;  // hidden bit included for normals
    rm_e                rm;
    logic               valid;
  } s1_t;

  // Reserved encodings 101..111 behave as round-to-nearest-even
  function automatic rm_e decode_rm(input logic [2:0] raw);
    rm_e r;
    case (raw)
      3'b000:  r = RM_RNE;
      3'b001:  r = RM_RTZ;
      3'b010:  r = RM_RDN;
      3'b011:  r = RM_RUP;
      3'b100:  r = RM_RMM;
      default: r = RM_RNE;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/fcvt_round_inc.sv
// Combinational round-up decision shared by the float/integer converters.
// Ports:
//   rm     - decoded rounding mode
//   sign   - sign of the value being rounded
//   lsb    - least significant kept bit of the magnitude
//   guard  - first discarded bit
//   sticky - OR of all remaining discarded bits
//   inc    - 1 when the kept magnitude must be incremented by one ulp
module fcvt_round_inc
  import fpu_pkg::*;
(
  input  rm_e  rm,
  input  logic sign,
  input  logic lsb,
  input  logic guard,
  input  logic sticky,
  output logic inc
);

  always_comb begin
    inc = 1'b0;
    case (rm)
      RM_RNE:  inc = guard & (sticky | lsb);
      RM_RTZ:  inc = 1'b0;
      RM_RDN:  inc = sign & (guard | sticky);
      RM_RUP:  inc = ~sign & (guard | sticky);
      RM_RMM:  inc = guard;
      default: inc = guard & (sticky | lsb);
    endcase
  end

endmodule

// File: rtl/fcvt_w_s.sv
// binary32 -> signed 32-bit integer converter (RISC-V FCVT.W.S), 3-stage
// pipeline: unpack/classify, align, round/negate/saturate.
// Optional build macro FCVT_W_S_UNSIGNED_EN adds port is_unsigned, which
// selects FCVT.WU.S semantics (range 0..0xFFFFFFFF).
// Ports:
//   clk, rst          - clock (rising edge), asynchronous active-high reset
//   en                - pipeline advance; 0 freezes every stage register
//   in_valid, x, rm   - operand, its valid tag and rounding mode
//   is_unsigned       - (optional) unsigned conversion select
//   out_valid         - y/flags valid, 3 enabled edges after in_valid
//   y                 - two's complement result
//   flag_nv, flag_nx  - invalid-operation and inexact flags
module fcvt_w_s
  import fpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        in_valid,
  input  logic [31:0] x,
  input  logic [2:0]  rm,
`ifdef FCVT_W_S_UNSIGNED_EN
  input  logic        is_unsigned,
`endif
  output logic        out_valid,
  output logic [31:0] y,
  output logic        flag_nv,
  output logic        flag_nx
);

  // Returns {nv, result}. sum is the rounded magnitude (33 bits so that a
  // carry out of an unsigned-range value is visible).
  function automatic logic [32:0] saturate(input logic uns, input logic sign,
                                           input logic nan, input logic inf,
                                           input logic ovf, input logic [32:0] sum);
    logic [32:0] r;
    r = 33'd0;
    if (uns) begin
      if (nan || (!sign && (inf || ovf || sum[32])))
        r = {1'b1, 32'hFFFF_FFFF};
      else if (sign && (inf || ovf || sum != 33'd0))
        r = {1'b1, 32'd0};
      else if (!sign)
        r = {1'b0, sum[31:0]};
    end else begin
      // -2^31 is representable, +2^31 is not
      if (nan || (!sign && (inf || ovf || sum >= 33'h0_8000_0000)))
        r = {1'b1, INT_MAX};
      else if (sign && (inf || ovf || sum > 33'h0_8000_0000))
        r = {1'b1, INT_MIN};
      else
        r = {1'b0, sign ? (32'd0 - sum[31:0]) : sum[31:0]};
    end
    return r;
  endfunction

  logic uns_in;
`ifdef FCVT_W_S_UNSIGNED_EN
  assign uns_in = is_unsigned;
`else
  assign uns_in = 1'b0;
`endif

  // ---- stage 1: unpack and classify ----
  s1_t        s1_d, s1_p1;
  logic       uns_p1;
  logic [7:0] exp_b;
  logic [22:0] frac;

  assign exp_b = x[30:23];
  assign frac  = x[22:0];

  always_comb begin
    s1_d       = '0;
    s1_d.sign  = x[31];
    s1_d.e     = $signed({1'b0, exp_b}) - $signed(9'(BIAS));
    s1_d.rm    = decode_rm(rm);
    s1_d.valid = in_valid;
    if (exp_b == 8'd0)
      s1_d.cls = (frac == 23'd0) ? CLS_ZERO : CLS_DENORM;
    else if (exp_b == 8'hFF)
      s1_d.cls = (frac != 23'd0) ? CLS_NAN : CLS_INF;
    else
      s1_d.cls = CLS_NORMAL;
    s1_d.mant = {(s1_d.cls == CLS_NORMAL), frac};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      s1_p1 <= '0;
    else if (en)
      s1_p1 <= s1_d;
  end

  always_ff @(posedge clk) begin
    if (en)
      uns_p1 <= uns_in;
  end

  // ---- stage 2: align mantissa to integer position ----
  logic signed [8:0] e_p1;
  logic [4:0]  lsh, rsh;
  logic [47:0] ext;
  logic [31:0] mag_d;
  logic        g_d, st_d, ovf_d;

  assign e_p1 = s1_p1.e;
  assign lsh  = 5'(e_p1 - 9'sd23);
  assign rsh  = 5'(9'sd23 - e_p1);
  // Right-shift window: kept bits land in [47:24], guard at [23], sticky below.
  // e = -1 falls out of the same path: magnitude 0, G = hidden bit, S = |M.
  assign ext  = {s1_p1.mant, 24'd0} >> rsh;

  always_comb begin
    mag_d = 32'd0;
    g_d   = 1'b0;
    st_d  = 1'b0;
    ovf_d = 1'b0;
    case (s1_p1.cls)
      CLS_DENORM: st_d = 1'b1;
      CLS_NORMAL: begin
        if (e_p1 > 9'sd31)
          ovf_d = 1'b1;
        else if (e_p1 >= 9'sd23)
          mag_d = {8'd0, s1_p1.mant} << lsh;
        else if (e_p1 >= -9'sd1) begin
          mag_d = {8'd0, ext[47:24]};
          g_d   = ext[23];
          st_d  = |ext[22:0];
        end else
          st_d = 1'b1;
      end
      default: ;
    endcase
  end

  logic        vld_p2;
  logic [31:0] mag_p2;
  logic        g_p2, st_p2, ovf_p2, sign_p2, nan_p2, inf_p2, uns_p2;
  rm_e         rm_p2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      vld_p2 <= 1'b0;
    else if (en)
      vld_p2 <= s1_p1.valid;
  end

  always_ff @(posedge clk) begin
    if (en) begin
      mag_p2  <= mag_d;
      g_p2    <= g_d;
      st_p2   <= st_d;
      ovf_p2  <= ovf_d;
      sign_p2 <= s1_p1.sign;
      nan_p2  <= (s1_p1.cls == CLS_NAN);
      inf_p2  <= (s1_p1.cls == CLS_INF);
      rm_p2   <= s1_p1.rm;
      uns_p2  <= uns_p1;
    end
  end

  // ---- stage 3: round, negate, saturate ----
  logic        inc;
  logic [32:0] sum;
  logic [32:0] sat;
  logic        nx_d;

  fcvt_round_inc u_round_inc (
    .rm     (rm_p2),
    .sign   (sign_p2),
    .lsb    (mag_p2[0]),
    .guard  (g_p2),
    .sticky (st_p2),
    .inc    (inc)
  );

  assign sum  = {1'b0, mag_p2} + {32'd0, inc};
  assign sat  = saturate(uns_p2, sign_p2, nan_p2, inf_p2, ovf_p2, sum);
  assign nx_d = (g_p2 | st_p2) & ~sat[32];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      y         <= 32'd0;
      flag_nv   <= 1'b0;
      flag_nx   <= 1'b0;
    end else if (en) begin
      out_valid <= vld_p2;
      // bubbles leave the last result visible
      if (vld_p2) begin
        y       <= sat[31:0];
        flag_nv <= sat[32];
        flag_nx <= nx_d;
      end
    end
  end

endmodule
